data_memory_arbiter: RTL and testbench

- Shares the single data memory port (data_memory_interface plus external bus) between two requesters: requester 0 is the core load/store unit, requester 1 is a DMA/debug port.
- Arbitrates round-robin and sequences each access through a small FSM.
- Waits a fixed memory read latency, then returns the formatted read data or a write acknowledge.
- Rejects misaligned accesses with an error response; rejected accesses never reach the bus.

---
 rtl/data_memory_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares the data memory port between requester 0 (core load/store unit)
//   and requester 1 (DMA/debug). Requests are granted round-robin in IDLE,
//   then sequenced ISSUE -> (WAIT for LATENCY cycles on loads) -> RESP.
//   Misaligned halves/words and format 2'b11 are answered with an error and
//   never strobe the bus.
//
// Ports
//   clock, reset_n                 rising-edge clock, async active-low reset
//   reqN_valid/ready               request handshake (ready only in IDLE)
//   reqN_write/address/format/wdata request attributes (format[2] = unsigned)
//   rspN_valid/error/rdata         one-cycle response pulse per accepted request
//   mem_address/data_format/write_data  to data_memory_interface
//   mem_read_enable/write_enable   bus strobes, one cycle in ISSUE
//   mem_read_data                  formatted read data, valid LATENCY cycles
//                                  after the read strobe
module data_memory_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_address,
  input  logic [2:0]  req0_format,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic        rsp0_error,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_address,
  input  logic [2:0]  req1_format,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic        rsp1_error,
  output logic [31:0] rsp1_rdata,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_data_format,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_LAST = 2'(LATENCY - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic        last_grant;
  logic        lat_write;
  logic        lat_err;
  logic        lat_id;

  logic        grant0;
  logic        grant1;
  logic        sel_write;
  logic [31:0] sel_address;
  logic [2:0]  sel_format;
  logic [31:0] sel_wdata;
  logic        sel_err;

  // Round-robin: on conflict the requester that did not win last time goes.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    sel_write   = grant1 ? req1_write   : req0_write;
    sel_address = grant1 ? req1_address : req0_address;
    sel_format  = grant1 ? req1_format  : req0_format;
    sel_wdata   = grant1 ? req1_wdata   : req0_wdata;
    sel_err     = 1'b0;
    case (sel_format[1:0])
      2'b01:   sel_err = sel_address[0];
      2'b10:   sel_err = |sel_address[1:0];
      2'b11:   sel_err = 1'b1;
      default: sel_err = 1'b0;
    endcase
  end

  // Gated with reset_n so ready is 0 while reset is held.
  assign req0_ready = grant0 & reset_n;
  assign req1_ready = grant1 & reset_n;

  // The alignment check is evaluated on the request at accept time and
  // latched, so the strobes can be registered straight into ISSUE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= '0;
      last_grant       <= 1'b1;
      lat_write        <= 1'b0;
      lat_err          <= 1'b0;
      lat_id           <= 1'b0;
      mem_address      <= '0;
      mem_data_format  <= '0;
      mem_write_data   <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      rsp0_valid       <= 1'b0;
      rsp0_error       <= 1'b0;
      rsp0_rdata       <= '0;
      rsp1_valid       <= 1'b0;
      rsp1_error       <= 1'b0;
      rsp1_rdata       <= '0;
    end else begin
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      rsp0_valid       <= 1'b0;
      rsp0_error       <= 1'b0;
      rsp0_rdata       <= '0;
      rsp1_valid       <= 1'b0;
      rsp1_error       <= 1'b0;
      rsp1_rdata       <= '0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            lat_write        <= sel_write;
            lat_err          <= sel_err;
            lat_id           <= grant1;
            last_grant       <= grant1;
            mem_address      <= sel_address;
            mem_data_format  <= sel_format;
            mem_write_data   <= sel_wdata;
            mem_write_enable <= sel_write & ~sel_err;
            mem_read_enable  <= ~sel_write & ~sel_err;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_write || lat_err) begin
            if (lat_id) begin
              rsp1_valid <= 1'b1;
              rsp1_error <= lat_err;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_error <= lat_err;
            end
            state <= RESP;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            if (lat_id) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= mem_read_data;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= mem_read_data;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Testbench for data_memory_arbiter: a LATENCY=1 instance exercised through
// a memory model and response/strobe scoreboards, and a LATENCY=3 instance
// for long-latency timing and mid-access reset.
module tb_data_memory_arbiter;

  localparam int DUT_LAT = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- LATENCY = 1 instance ----------------
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_address, req0_wdata;
  logic [2:0]  req0_format;
  logic        rsp0_valid, rsp0_error;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_address, req1_wdata;
  logic [2:0]  req1_format;
  logic        rsp1_valid, rsp1_error;
  logic [31:0] rsp1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_data_format;
  logic        mem_read_enable, mem_write_enable;

  data_memory_arbiter #(.LATENCY(DUT_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_address(req0_address), .req0_format(req0_format), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_error(rsp0_error), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_address(req1_address), .req1_format(req1_format), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_error(rsp1_error), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_data_format(mem_data_format),
    .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  // Memory model standing in for data_memory_interface.
  logic [31:0] mem_words [0:255];
  int          rd_cyc = 0;
  logic        rd_any = 1'b0;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f[1:0])
      2'b00:   return f[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Read data is only meaningful from DUT_LAT cycles after the read strobe.
  assign mem_read_data = (rd_any && cyc >= rd_cyc + DUT_LAT)
    ? fmt_load(mem_words[mem_address[9:2]], mem_address[1:0], mem_data_format)
    : 32'hBAADF00D;

  always @(negedge clock) begin
    if (reset_n && mem_read_enable) begin
      rd_cyc <= cyc;
      rd_any <= 1'b1;
    end
    if (reset_n && mem_write_enable) begin
      case (mem_data_format[1:0])
        2'b00: mem_words[mem_address[9:2]][8*mem_address[1:0] +: 8] <= mem_write_data[7:0];
        2'b01: begin
          if (mem_address[1]) mem_words[mem_address[9:2]][31:16] <= mem_write_data[15:0];
          else                mem_words[mem_address[9:2]][15:0]  <= mem_write_data[15:0];
        end
        default: mem_words[mem_address[9:2]] <= mem_write_data;
      endcase
    end
  end

  typedef struct {int c; int lat; logic err; logic [31:0] rd;} rsp_t;
  typedef struct {int c; logic wr; logic [31:0] a;} strobe_t;
  rsp_t    q0[$];
  rsp_t    q1[$];
  strobe_t sq[$];
  int      glog[$];

  always @(negedge clock) begin : mon1
    strobe_t s;
    rsp_t    r;
    if (reset_n) begin
      if (mem_read_enable || mem_write_enable) begin
        if (sq.size() == 0) check_val("strobe_unexpected", 32'd1, 32'd0);
        else begin
          s = sq.pop_front();
          check_val("strobe_cycle", 32'(cyc), 32'(s.c));
          check_val("strobe_write", 32'(mem_write_enable), 32'(s.wr));
          check_val("strobe_read", 32'(mem_read_enable), 32'(!s.wr));
          check_val("strobe_addr", mem_address, s.a);
        end
      end
      if (rsp0_valid) begin
        if (q0.size() == 0) check_val("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          r = q0.pop_front();
          check_val("rsp0_latency", 32'(cyc - r.c), 32'(r.lat));
          check_val("rsp0_error", 32'(rsp0_error), 32'(r.err));
          check_val("rsp0_rdata", rsp0_rdata, r.rd);
        end
      end
      if (rsp1_valid) begin
        if (q1.size() == 0) check_val("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          r = q1.pop_front();
          check_val("rsp1_latency", 32'(cyc - r.c), 32'(r.lat));
          check_val("rsp1_error", 32'(rsp1_error), 32'(r.err));
          check_val("rsp1_rdata", rsp1_rdata, r.rd);
        end
      end
    end
  end

  task automatic set_valid(input int p, input logic v);
    if (p == 0) req0_valid = v; else req1_valid = v;
  endtask

  // Present a request, wait (bounded) for acceptance, push expectations.
  task automatic send(input int p, input logic w, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] d, input logic e, input logic [31:0] rd);
    rsp_t    r;
    strobe_t s;
    logic    got;
    got = 1'b0;
    @(negedge clock);
    if (p == 0) begin
      req0_write = w; req0_address = a; req0_format = f; req0_wdata = d;
    end else begin
      req1_write = w; req1_address = a; req1_format = f; req1_wdata = d;
    end
    set_valid(p, 1'b1);
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        got   = 1'b1;
        r.c   = cyc;
        r.lat = (w || e) ? 2 : DUT_LAT + 2;
        r.err = e;
        r.rd  = rd;
        if (p == 0) q0.push_back(r); else q1.push_back(r);
        if (!e) begin
          s.c = cyc + 1; s.wr = w; s.a = a;
          sq.push_back(s);
        end
        glog.push_back(p);
        @(posedge clock);
        #1;
        set_valid(p, 1'b0);
      end else begin
        @(negedge clock);
      end
    end
    if (!got) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      set_valid(p, 1'b0);
    end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && sq.size() == 0) break;
    end
    if (i == 100) check_val("drain_timeout", 32'(q0.size() + q1.size() + sq.size()), 32'd0);
  endtask

  // ---------------- LATENCY = 3 instance ----------------
  logic        d3_rst_n;
  logic        d3_req0_valid, d3_req0_ready, d3_req0_write;
  logic [31:0] d3_req0_address, d3_req0_wdata;
  logic [2:0]  d3_req0_format;
  logic        d3_rsp0_valid, d3_rsp0_error;
  logic [31:0] d3_rsp0_rdata;
  logic        d3_req1_valid, d3_req1_ready, d3_req1_write;
  logic [31:0] d3_req1_address, d3_req1_wdata;
  logic [2:0]  d3_req1_format;
  logic        d3_rsp1_valid, d3_rsp1_error;
  logic [31:0] d3_rsp1_rdata;
  logic [31:0] d3_mem_address, d3_mem_write_data, d3_mem_read_data;
  logic [2:0]  d3_mem_data_format;
  logic        d3_mem_read_enable, d3_mem_write_enable;
  int          d3_rd_cyc = 0;
  logic        d3_rd_any = 1'b0;
  int          d3_nstrobe = 0;
  int          d3_nrsp = 0;

  data_memory_arbiter #(.LATENCY(3)) dut3 (
    .clock(clock), .reset_n(d3_rst_n),
    .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_write(d3_req0_write),
    .req0_address(d3_req0_address), .req0_format(d3_req0_format), .req0_wdata(d3_req0_wdata),
    .rsp0_valid(d3_rsp0_valid), .rsp0_error(d3_rsp0_error), .rsp0_rdata(d3_rsp0_rdata),
    .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready), .req1_write(d3_req1_write),
    .req1_address(d3_req1_address), .req1_format(d3_req1_format), .req1_wdata(d3_req1_wdata),
    .rsp1_valid(d3_rsp1_valid), .rsp1_error(d3_rsp1_error), .rsp1_rdata(d3_rsp1_rdata),
    .mem_address(d3_mem_address), .mem_data_format(d3_mem_data_format),
    .mem_write_data(d3_mem_write_data), .mem_read_enable(d3_mem_read_enable),
    .mem_write_enable(d3_mem_write_enable), .mem_read_data(d3_mem_read_data)
  );

  assign d3_mem_read_data = (d3_rd_any && cyc >= d3_rd_cyc + 3) ? 32'hCAFEF00D : 32'hBAADF00D;

  always @(negedge clock) begin
    if (d3_rst_n) begin
      if (d3_mem_read_enable) begin
        d3_rd_cyc <= cyc;
        d3_rd_any <= 1'b1;
      end
      if (d3_mem_read_enable || d3_mem_write_enable) d3_nstrobe <= d3_nstrobe + 1;
      if (d3_rsp0_valid || d3_rsp1_valid) d3_nrsp <= d3_nrsp + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int snap_s, snap_r;
    for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
    mem_words[32'h100 >> 2] = 32'hDEADBEEF;
    mem_words[32'h200 >> 2] = 32'h80000000;

    reset_n = 1'b0; d3_rst_n = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_address = 32'h100; req0_format = 3'b010; req0_wdata = '0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_address = 32'h0;   req1_format = 3'b010; req1_wdata = '0;
    d3_req0_valid = 1'b0; d3_req0_write = 1'b0; d3_req0_address = '0; d3_req0_format = 3'b010; d3_req0_wdata = '0;
    d3_req1_valid = 1'b0; d3_req1_write = 1'b0; d3_req1_address = '0; d3_req1_format = '0; d3_req1_wdata = '0;

    // Reset state: outputs zero even with requests presented.
    repeat (3) @(negedge clock);
    check_val("reset_ready0", 32'(req0_ready), 32'd0);
    check_val("reset_ready1", 32'(req1_ready), 32'd0);
    check_val("reset_strobes", 32'({mem_read_enable, mem_write_enable}), 32'd0);
    check_val("reset_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_error, rsp1_error}), 32'd0);
    check_val("reset_addr", mem_address, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1; d3_rst_n = 1'b1;

    // Load word, response at T+3.
    send(0, 1'b0, 32'h100, 3'b010, '0, 1'b0, 32'hDEADBEEF);
    drain();

    // Conflicts after a fresh reset: 0, then 1, then 0 again, then 1.
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    glog.delete();
    fork
      send(0, 1'b1, 32'h0, 3'b010, 32'h11223344, 1'b0, 32'h0);
      send(1, 1'b0, 32'h0, 3'b010, '0, 1'b0, 32'h11223344);
    join
    fork
      send(0, 1'b0, 32'h0, 3'b010, '0, 1'b0, 32'h11223344);
      send(1, 1'b1, 32'h1, 3'b000, 32'h000000AB, 1'b0, 32'h0);
    join
    drain();
    check_val("grant_count", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      check_val("grant_0", 32'(glog[0]), 32'd0);
      check_val("grant_1", 32'(glog[1]), 32'd1);
      check_val("grant_2", 32'(glog[2]), 32'd0);
      check_val("grant_3", 32'(glog[3]), 32'd1);
    end
    send(0, 1'b0, 32'h1, 3'b100, '0, 1'b0, 32'h000000AB);

    // Byte loads, signed and unsigned.
    send(1, 1'b0, 32'h203, 3'b000, '0, 1'b0, 32'hFFFFFF80);
    send(1, 1'b0, 32'h203, 3'b100, '0, 1'b0, 32'h00000080);

    // Errors never strobe; legal halves do.
    send(0, 1'b1, 32'h101, 3'b001, 32'h5555AAAA, 1'b1, 32'h0);
    send(0, 1'b1, 32'h100, 3'b011, 32'h12345678, 1'b1, 32'h0);
    send(0, 1'b0, 32'h102, 3'b010, '0, 1'b1, 32'h0);
    send(0, 1'b0, 32'h102, 3'b001, '0, 1'b0, 32'hFFFFDEAD);
    send(1, 1'b0, 32'h102, 3'b101, '0, 1'b0, 32'h0000DEAD);
    drain();

    // A req1 request raised and dropped while busy is ignored.
    fork
      send(0, 1'b0, 32'h100, 3'b010, '0, 1'b0, 32'hDEADBEEF);
      begin
        @(negedge clock); @(negedge clock);
        req1_write = 1'b0; req1_address = 32'h200; req1_format = 3'b010;
        req1_valid = 1'b1;
        #1 check_val("busy_ready1_a", 32'(req1_ready), 32'd0);
        @(negedge clock);
        #1 check_val("busy_ready1_b", 32'(req1_ready), 32'd0);
        req1_valid = 1'b0;
      end
    join
    drain();
    repeat (4) @(negedge clock);

    // LATENCY=3: response at T+5, address stable from T+1 to T+4.
    d3_req0_address = 32'h40; d3_req0_format = 3'b010; d3_req0_write = 1'b0;
    d3_req0_valid = 1'b1;
    #1 check_val("d3_ready", 32'(d3_req0_ready), 32'd1);
    t = cyc;
    @(posedge clock); #1 d3_req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check_val("d3_addr_stable", d3_mem_address, 32'h40);
      check_val("d3_no_early_rsp", 32'(d3_rsp0_valid), 32'd0);
      if (k == 1) check_val("d3_read_strobe", 32'(d3_mem_read_enable), 32'd1);
    end
    @(negedge clock);
    check_val("d3_rsp_cycle", 32'(cyc - t), 32'd5);
    check_val("d3_rsp_valid", 32'(d3_rsp0_valid), 32'd1);
    check_val("d3_rsp_rdata", d3_rsp0_rdata, 32'hCAFEF00D);
    check_val("d3_rsp_error", 32'(d3_rsp0_error), 32'd0);
    repeat (2) @(negedge clock);

    // Reset pulsed at T+2 of a load: outputs clear at once, nothing follows.
    d3_req0_address = 32'h44; d3_req0_valid = 1'b1;
    #1 check_val("d3_ready2", 32'(d3_req0_ready), 32'd1);
    @(posedge clock); #1 d3_req0_valid = 1'b0;
    @(posedge clock); #2 d3_rst_n = 1'b0;
    #1;
    check_val("d3_reset_addr", d3_mem_address, 32'd0);
    check_val("d3_reset_ctl", 32'({d3_mem_read_enable, d3_mem_write_enable, d3_rsp0_valid,
              d3_rsp1_valid, d3_rsp0_error, d3_rsp1_error, d3_req0_ready, d3_req1_ready}), 32'd0);
    check_val("d3_reset_data", d3_rsp0_rdata | d3_rsp1_rdata | d3_mem_write_data, 32'd0);
    @(negedge clock); d3_rst_n = 1'b1;
    snap_s = d3_nstrobe; snap_r = d3_nrsp;
    repeat (10) @(negedge clock);
    check_val("d3_no_strobe_after_reset", 32'(d3_nstrobe - snap_s), 32'd0);
    check_val("d3_no_rsp_after_reset", 32'(d3_nrsp - snap_r), 32'd0);

    check_val("left_q0", 32'(q0.size()), 32'd0);
    check_val("left_q1", 32'(q1.size()), 32'd0);
    check_val("left_strobes", 32'(sq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
